// File: rtl/noc_flit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_flit_pkg
// Description : Shared flit layout, LFSR constants, FSM state encoding and
//               helper functions for the NoC flit source.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_flit_pkg;

    localparam int FLIT_W  = 20;
    localparam int SRC_MSB = 19;
    localparam int SRC_LSB = 16;
    localparam int SEQ_MSB = 15;
    localparam int SEQ_LSB = 4;
    localparam int DEST_W  = 4;

    localparam logic [15:0] LFSR_MASK    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAPW = 2'd2,
        ST_DONE = 2'd3
    } flit_state_e;

    // Galois form: shift right, fold the mask in when the outgoing LSB is set.
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        logic [15:0] nxt;
        nxt = {1'b0, cur[15:1]};
        if (cur[0]) begin
            nxt = nxt ^ LFSR_MASK;
        end
        return nxt;
    endfunction

    function automatic logic [DEST_W-1:0] dest_sel(
        input logic [11:0]       rnd,
        input logic [DEST_W-1:0] src,
        input logic [DEST_W-1:0] hot,
        input logic [8:0]        thresh
    );
        logic [DEST_W-1:0] d;
        if ((src != hot) && ({1'b0, rnd[7:0]} < thresh)) begin
            d = hot;
        end else begin
            d = rnd[11:8];
            if (d == src) begin
                d = d + 4'd1;
            end
        end
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/noc_lfsr16.sv
`default_nettype none
// ============================================================================
// Module      : noc_lfsr16
// Description : 16-bit Galois LFSR, advances one step per adv pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_lfsr16
    import noc_flit_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        adv,
    output logic [15:0] state
);

    // An all-zero seed would lock the register up.
    localparam logic [15:0] C_SEED = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;

    logic [15:0] state_d;
    logic [15:0] state_q;

    always_comb begin
        state_d = state_q;
        if (adv) begin
            state_d = lfsr_step(state_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= C_SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule
`default_nettype wire

// File: rtl/flit_source_gen.sv
`default_nettype none
// ============================================================================
// Module      : flit_source_gen
// Description : Programmable flit injection source with hotspot-biased
//               destinations and valid/ready output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module flit_source_gen
    import noc_flit_pkg::*;
#(
    parameter int          SRC_ID         = 0,
    parameter int          HOTSPOT_ID     = 5,
    parameter int          HOTSPOT_THRESH = 128,
    parameter int          NUM_FLITS      = 64,
    parameter int          GAP            = 0,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [FLIT_W-1:0] dataout,
    output logic              busy,
    output logic              done,
    output logic [11:0]       sent_count,
    output logic [11:0]       hot_count
);

    localparam logic [DEST_W-1:0] C_SRC    = SRC_ID[DEST_W-1:0];
    localparam logic [DEST_W-1:0] C_HOT    = HOTSPOT_ID[DEST_W-1:0];
    localparam logic [8:0]        C_THRESH = HOTSPOT_THRESH[8:0];
    localparam logic [11:0]       C_NUM    = NUM_FLITS[11:0];
    localparam logic [7:0]        C_GAP    = GAP[7:0];

    flit_state_e       state_d, state_q;
    logic [FLIT_W-1:0] dataout_d, dataout_q;
    logic [11:0]       seq_d, seq_q;
    logic [11:0]       sent_d, sent_q;
    logic [11:0]       hot_d, hot_q;
    logic [7:0]        gap_d, gap_q;

    logic        xfer;
    logic [15:0] lfsr_cur;
    logic [15:0] lfsr_nxt;

    noc_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .adv   (xfer),
        .state (lfsr_cur)
    );

    assign xfer     = (state_q == ST_SEND) && out_ready;
    // The flit following a transfer is built from the value the LFSR is about to take.
    assign lfsr_nxt = lfsr_step(lfsr_cur);

    always_comb begin
        state_d   = state_q;
        dataout_d = dataout_q;
        seq_d     = seq_q;
        sent_d    = sent_q;
        hot_d     = hot_q;
        gap_d     = gap_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    seq_d     = 12'd0;
                    sent_d    = 12'd0;
                    hot_d     = 12'd0;
                    dataout_d = {C_SRC, 12'd0,
                                 dest_sel(lfsr_cur[11:0], C_SRC, C_HOT, C_THRESH)};
                    state_d   = (C_NUM == 12'd0) ? ST_DONE : ST_SEND;
                end
            end
            ST_SEND: begin
                if (out_ready) begin
                    sent_d = sent_q + 12'd1;
                    if (dataout_q[DEST_W-1:0] == C_HOT) begin
                        hot_d = hot_q + 12'd1;
                    end
                    seq_d     = seq_q + 12'd1;
                    dataout_d = {C_SRC, seq_q + 12'd1,
                                 dest_sel(lfsr_nxt[11:0], C_SRC, C_HOT, C_THRESH)};
                    if ((sent_q + 12'd1) == C_NUM) begin
                        state_d = ST_DONE;
                    end else if (C_GAP == 8'd0) begin
                        state_d = ST_SEND;
                    end else begin
                        state_d = ST_GAPW;
                        gap_d   = C_GAP;
                    end
                end
            end
            ST_GAPW: begin
                if (gap_q == 8'd1) begin
                    state_d = ST_SEND;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            dataout_q <= '0;
            seq_q     <= 12'd0;
            sent_q    <= 12'd0;
            hot_q     <= 12'd0;
            gap_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            dataout_q <= dataout_d;
            seq_q     <= seq_d;
            sent_q    <= sent_d;
            hot_q     <= hot_d;
            gap_q     <= gap_d;
        end
    end

    assign out_valid  = (state_q == ST_SEND);
    assign busy       = (state_q == ST_SEND) || (state_q == ST_GAPW);
    assign done       = (state_q == ST_DONE);
    assign dataout    = dataout_q;
    assign sent_count = sent_q;
    assign hot_count  = hot_q;

endmodule
`default_nettype wire

// File: tb/tb_flit_source_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_flit_source_gen
// Description : Directed self-checking bench for flit_source_gen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flit_source_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // a: forced hotspot, 4 flits; g: gap 3; z: zero flits;
    // d: distribution with SRC 2; h: 50 % hotspot, 4000 flits
    logic rst_a, start_a, ready_a, valid_a, busy_a, done_a;
    logic rst_g, start_g, ready_g, valid_g, busy_g, done_g;
    logic rst_z, start_z, ready_z, valid_z, busy_z, done_z;
    logic rst_d, start_d, ready_d, valid_d, busy_d, done_d;
    logic rst_h, start_h, ready_h, valid_h, busy_h, done_h;
    logic [19:0] data_a, data_g, data_z, data_d, data_h;
    logic [11:0] sent_a, sent_g, sent_z, sent_d, sent_h;
    logic [11:0] hot_a, hot_g, hot_z, hot_d, hot_h;

    flit_source_gen #(.SRC_ID(0), .HOTSPOT_ID(5), .HOTSPOT_THRESH(256), .NUM_FLITS(4), .GAP(0))
    u_a (.clk(clk), .rst(rst_a), .start(start_a), .out_ready(ready_a), .out_valid(valid_a),
         .dataout(data_a), .busy(busy_a), .done(done_a), .sent_count(sent_a), .hot_count(hot_a));

    flit_source_gen #(.SRC_ID(0), .HOTSPOT_ID(5), .HOTSPOT_THRESH(256), .NUM_FLITS(3), .GAP(3))
    u_g (.clk(clk), .rst(rst_g), .start(start_g), .out_ready(ready_g), .out_valid(valid_g),
         .dataout(data_g), .busy(busy_g), .done(done_g), .sent_count(sent_g), .hot_count(hot_g));

    flit_source_gen #(.SRC_ID(0), .HOTSPOT_ID(5), .HOTSPOT_THRESH(128), .NUM_FLITS(0), .GAP(0))
    u_z (.clk(clk), .rst(rst_z), .start(start_z), .out_ready(ready_z), .out_valid(valid_z),
         .dataout(data_z), .busy(busy_z), .done(done_z), .sent_count(sent_z), .hot_count(hot_z));

    flit_source_gen #(.SRC_ID(2), .HOTSPOT_ID(5), .HOTSPOT_THRESH(0), .NUM_FLITS(1000), .GAP(0))
    u_d (.clk(clk), .rst(rst_d), .start(start_d), .out_ready(ready_d), .out_valid(valid_d),
         .dataout(data_d), .busy(busy_d), .done(done_d), .sent_count(sent_d), .hot_count(hot_d));

    flit_source_gen #(.SRC_ID(0), .HOTSPOT_ID(5), .HOTSPOT_THRESH(128), .NUM_FLITS(4000), .GAP(0))
    u_h (.clk(clk), .rst(rst_h), .start(start_h), .out_ready(ready_h), .out_valid(valid_h),
         .dataout(data_h), .busy(busy_h), .done(done_h), .sent_count(sent_h), .hot_count(hot_h));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] m_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [3:0] m_dest(input logic [15:0] s, input int src, input int hot,
                                          input int thresh);
        logic [3:0] d;
        if ((src != hot) && (int'(s[7:0]) < thresh)) return hot[3:0];
        d = s[11:8];
        if (d == src[3:0]) d = d + 4'd1;
        return d;
    endfunction

    initial begin
        logic [8:0]  pat;
        logic        vseen;
        logic [15:0] s;
        logic [19:0] exp_flit;
        int k, bad, selfd, ohot, cyc;

        {rst_a, rst_g, rst_z, rst_d, rst_h} = '0;
        {start_a, start_g, start_z, start_d, start_h} = '0;
        {ready_a, ready_g, ready_z, ready_d, ready_h} = '0;
        tick();
        tick();
        chk("reset_valid", {31'd0, valid_a}, 32'd0);
        chk("reset_data",  {12'd0, data_a}, 32'd0);
        chk("reset_flags", {30'd0, busy_a, done_a}, 32'd0);
        chk("reset_cnts",  {8'd0, sent_a, hot_a}, 32'd0);
        {rst_a, rst_g, rst_z, rst_d, rst_h} = '1;
        tick();

        // forced hotspot run
        ready_a = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("hs_flit0", {11'd0, valid_a, data_a}, 32'h0010_0005);
        tick();
        chk("hs_flit1", {12'd0, data_a}, 32'h0_0015);
        tick();
        chk("hs_flit2", {12'd0, data_a}, 32'h0_0025);
        tick();
        chk("hs_flit3", {12'd0, data_a}, 32'h0_0035);
        tick();
        chk("hs_end_flags", {29'd0, done_a, busy_a, valid_a}, 32'h4);
        chk("hs_sent", {20'd0, sent_a}, 32'd4);
        chk("hs_hot", {20'd0, hot_a}, 32'd4);

        // backpressure during flit 2, with a start pulse while busy
        ready_a = 1'b0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("bp_flit0", {12'd0, data_a}, 32'h0_0005);
        ready_a = 1'b1;
        tick();
        tick();
        chk("bp_flit2", {12'd0, data_a}, 32'h0_0025);
        ready_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            start_a = (i == 2);
            tick();
            start_a = 1'b0;
            chk("bp_hold", {11'd0, valid_a, data_a}, 32'h0010_0025);
        end
        chk("bp_sent_mid", {20'd0, sent_a}, 32'd2);
        ready_a = 1'b1;
        tick();
        chk("bp_flit3", {12'd0, data_a}, 32'h0_0035);
        tick();
        chk("bp_done", {31'd0, done_a}, 32'd1);
        chk("bp_sent", {20'd0, sent_a}, 32'd4);

        // gap spacing
        ready_g = 1'b1;
        start_g = 1'b1;
        tick();
        start_g = 1'b0;
        pat = '0;
        for (int i = 0; i < 9; i++) begin
            pat[8-i] = valid_g;
            tick();
        end
        chk("gap_pattern", {23'd0, pat}, 32'h111);
        chk("gap_done", {31'd0, done_g}, 32'd1);
        chk("gap_sent", {20'd0, sent_g}, 32'd3);

        // zero-length run
        start_z = 1'b1;
        tick();
        start_z = 1'b0;
        chk("zero_done", {30'd0, done_z, busy_z}, 32'h2);
        vseen = valid_z;
        repeat (3) begin
            tick();
            vseen = vseen | valid_z;
        end
        chk("zero_no_valid", {31'd0, vseen}, 32'd0);
        chk("zero_sent", {20'd0, sent_z}, 32'd0);

        // reset while flit 7 is pending
        ready_h = 1'b1;
        start_h = 1'b1;
        tick();
        start_h = 1'b0;
        repeat (7) tick();
        ready_h = 1'b0;
        chk("mid_pending", {11'd0, valid_h, 8'd0, data_h[15:4]}, 32'h0010_0007);
        rst_h = 1'b0;
        tick();
        chk("mid_rst_state", {29'd0, valid_h, busy_h, done_h}, 32'd0);
        chk("mid_rst_cnts", {8'd0, sent_h, hot_h}, 32'd0);
        chk("mid_rst_data", {12'd0, data_h}, 32'd0);
        rst_h = 1'b1;
        tick();

        // distribution: no self-addressed flits, destinations follow the LFSR
        s = 16'hACE1;
        k = 0; bad = 0; selfd = 0; ohot = 0; cyc = 0;
        ready_d = 1'b1;
        start_d = 1'b1;
        tick();
        start_d = 1'b0;
        while (!done_d && cyc < 1100) begin
            if (valid_d) begin
                exp_flit = {4'd2, k[11:0], m_dest(s, 2, 5, 0)};
                if (data_d !== exp_flit) bad++;
                if (data_d[3:0] == 4'd2) selfd++;
                if (data_d[3:0] == 4'd5) ohot++;
                k++;
                s = m_next(s);
            end
            tick();
            cyc++;
        end
        chk("dist_done", {31'd0, done_d}, 32'd1);
        chk("dist_flit_mismatches", bad, 32'd0);
        chk("dist_self_addr", selfd, 32'd0);
        chk("dist_count", k, 32'd1000);
        chk("dist_sent", {20'd0, sent_d}, 32'd1000);
        chk("dist_hot", {20'd0, hot_d}, ohot);

        // 50 % hotspot, long run
        s = 16'hACE1;
        k = 0; bad = 0; ohot = 0; cyc = 0;
        ready_h = 1'b1;
        start_h = 1'b1;
        tick();
        start_h = 1'b0;
        while (!done_h && cyc < 4100) begin
            if (valid_h) begin
                exp_flit = {4'd0, k[11:0], m_dest(s, 0, 5, 128)};
                if (data_h !== exp_flit) bad++;
                if (data_h[3:0] == 4'd5) ohot++;
                k++;
                s = m_next(s);
            end
            tick();
            cyc++;
        end
        chk("h50_done", {31'd0, done_h}, 32'd1);
        chk("h50_flit_mismatches", bad, 32'd0);
        chk("h50_sent", {20'd0, sent_h}, 32'd4000);
        chk("h50_hot", {20'd0, hot_h}, ohot);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
